// File: rtl/dsd_defs_pkg.sv
// Shared lab definitions: FSM state encoding and common constants.
package dsd_defs;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder_behavioural.sv
// Combinational 1-bit full adder cell.
module full_adder_behavioural (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/serial_adder_fsm.sv
// Bit-serial WIDTH-bit adder: one full-adder cell reused LSB-first, with
// a start/busy/done handshake and registered sum/cout.
module serial_adder_fsm
  import dsd_defs::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] sa, sb, ps;
  logic             c;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_c;

  full_adder_behavioural u_fa (
    .A   (sa[0]),
    .B   (sb[0]),
    .Cin (c),
    .S   (fa_s),
    .Cout(fa_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      ps    <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            c     <= cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          c   <= fa_c;
          ps  <= {fa_s, ps[WIDTH-1:1]};
          sa  <= {1'b0, sa[WIDTH-1:1]};
          sb  <= {1'b0, sb[WIDTH-1:1]};
          cnt <= cnt + CW'(1);
          // Last bit: publish the fully shifted sum and final carry together.
          if (cnt == LAST) begin
            sum   <= {fa_s, ps[WIDTH-1:1]};
            cout  <= fa_c;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Both decode a register directly, so outputs stay free of input paths.
  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Directed self-checking bench for serial_adder_fsm (WIDTH=8).
module tb_serial_adder_fsm;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic             busy, done, cout;
  logic [WIDTH-1:0] sum;

  int n_chk  = 0;
  int n_fail = 0;

  serial_adder_fsm #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation, scramble operands afterwards, check latency and result.
  task automatic run_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                        input logic vc, input logic [7:0] es, input logic ec);
    int k;
    logic gap;
    a = va; b = vb; cin = vc; start = 1'b1;
    tick();
    start = 1'b0;
    a = 8'hA5; b = 8'h5A; cin = ~vc;
    gap = 1'b0;
    for (k = 1; k <= 20; k++) begin
      tick();
      if (done) break;
      if (!busy) gap = 1'b1;
    end
    chk({tag, "_lat"}, k, 8);
    chk({tag, "_busy_run"}, gap, 0);
    chk({tag, "_busy_done"}, busy, 0);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    tick();
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int npulse, tfirst, tprev, lowbusy;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    rst_n = 1'b1;
    tick();

    run_op("basic", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0);
    run_op("wrap", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op("max", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    run_op("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);

    // Start pulses during RUN must be ignored.
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    npulse = 0;
    for (int i = 1; i <= 14; i++) begin
      if (i == 2 || i == 5) begin a = 8'h7F; b = 8'h7F; start = 1'b1; end
      else start = 1'b0;
      tick();
      if (done) npulse++;
    end
    start = 1'b0;
    chk("ign_pulses", npulse, 1);
    chk("ign_sum", sum, 8'h30);
    chk("ign_cout", cout, 0);

    // Reset sampled while cnt==4 aborts the operation.
    a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 0);
    npulse = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) npulse++;
    end
    chk("abort_nodone", npulse, 0);
    run_op("after_abort", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0);

    // Start held high: back-to-back operations every WIDTH+2 cycles.
    a = 8'h03; b = 8'h04; cin = 1'b0; start = 1'b1;
    npulse = 0; tfirst = 0; tprev = 0; lowbusy = 0;
    for (int i = 1; i <= 45; i++) begin
      tick();
      if (done) begin
        npulse++;
        if (npulse == 1) tfirst = i;
        else chk("hold_period", i - tprev, 10);
        tprev = i;
        chk("hold_sum", sum, 8'h07);
      end
      if (npulse >= 1 && npulse < 3 && !busy) lowbusy++;
    end
    start = 1'b0;
    chk("hold_npulse_ge3", (npulse >= 3), 1);
    chk("hold_first_lat", tfirst, 9);
    chk("hold_busy_low", lowbusy, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
